// File: rtl/accum_array.sv
// rtl/accum_array.sv - 64-bit word-count accumulator table with RMW forwarding, clear and AXI-Stream drain
module accum_array #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   accum_addr,
  input  logic [63:0]   accum_din,
  input  logic          accum_we,
  input  logic          clear_kick,
  input  logic          drain_kick,
  output logic          busy,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [511:0]  m_axis_tdata,
  output logic          m_axis_tlast,
  output logic [31:0]   dropped_count
);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    CLEAR,
    DRAIN_RD,
    DRAIN_OUT
  } state_t;

  localparam logic [31:0]       DEPTH_W    = 32'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

  state_t state;
  logic   kick_clear;

  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] dr_addr;
  logic [3:0]        dr_cnt;
  logic [2:0]        pk_slot;

  // RMW pipeline: A holds the accepted update, R is the cycle the RAM read
  // is in flight, W tracks the sum written last cycle for forwarding.
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [63:0]       a_din;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_din;
  logic              w_valid;
  logic [ADDR_W-1:0] w_addr;
  logic [63:0]       w_sum;

  logic [63:0]       mem [DEPTH];
  logic [63:0]       ram_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [63:0]       ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;

  logic        in_range;
  logic        accept;
  logic        drop;
  logic        fwd_sel;
  logic [63:0] sum;
  logic        clr_done;

  always_comb begin
    in_range  = accum_addr < DEPTH_W;
    accept    = accum_we && in_range && (state == IDLE);
    drop      = accum_we && !accept;
    fwd_sel   = w_valid && (w_addr == r_addr);
    sum       = (fwd_sel ? w_sum : ram_q) + r_din;
    clr_done  = (state == CLEAR) && (clr_addr == LAST_ENTRY);
    pk_slot   = 3'(dr_cnt - 4'd1);
    ram_raddr = (state == DRAIN_RD) ? dr_addr : a_addr;
    ram_we    = 1'b0;
    ram_waddr = r_addr;
    ram_wdata = sum;
    if (state == CLEAR) begin
      ram_we    = !reset;
      ram_waddr = clr_addr;
      ram_wdata = 64'd0;
    end else if (r_valid) begin
      ram_we    = !reset;
    end
  end

  // Read-first single-port-style table; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    ram_q <= mem[ram_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid <= 1'b0;
      r_valid <= 1'b0;
      w_valid <= 1'b0;
      a_addr  <= '0;
      a_din   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      w_addr  <= '0;
      w_sum   <= '0;
    end else begin
      a_valid <= accept;
      a_addr  <= accum_addr[ADDR_W-1:0];
      a_din   <= accum_din;
      r_valid <= a_valid;
      r_addr  <= a_addr;
      r_din   <= a_din;
      w_valid <= r_valid;
      w_addr  <= r_addr;
      w_sum   <= sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dropped_count <= '0;
    end else if (clr_done) begin
      dropped_count <= '0;
    end else if (drop && (dropped_count != 32'hFFFF_FFFF)) begin
      dropped_count <= dropped_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      kick_clear    <= 1'b0;
      busy          <= 1'b0;
      clr_addr      <= '0;
      dr_addr       <= '0;
      dr_cnt        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_kick || drain_kick) begin
            kick_clear <= clear_kick;
            busy       <= 1'b1;
            state      <= FLUSH;
          end
        end
        FLUSH: begin
          // Once A is empty, the last in-flight sum lands this cycle, so the
          // following clear or drain read sees a settled table.
          if (!a_valid) begin
            if (kick_clear) begin
              clr_addr <= '0;
              state    <= CLEAR;
            end else begin
              dr_addr <= '0;
              dr_cnt  <= '0;
              state   <= DRAIN_RD;
            end
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DRAIN_RD: begin
          // Reads issue on counts 0..7; data for the read from the previous
          // count is packed one cycle later, count 8 closes the beat.
          if (dr_cnt != 4'd8) begin
            dr_addr <= dr_addr + 1'b1;
          end
          if (dr_cnt != 4'd0) begin
            m_axis_tdata[64*pk_slot +: 64] <= ram_q;
          end
          if (dr_cnt == 4'd8) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (dr_addr == '0);
            state         <= DRAIN_OUT;
          end
          dr_cnt <= dr_cnt + 4'd1;
        end
        DRAIN_OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            dr_cnt        <= '0;
            if (m_axis_tlast) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= DRAIN_RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_array.sv
// tb/tb_accum_array.sv - directed self-checking bench for accum_array at DEPTH=16
module tb_accum_array;

  localparam int DEPTH = 16;
  localparam int NB    = DEPTH / 8;

  logic         clk;
  logic         reset;
  logic [31:0]  accum_addr;
  logic [63:0]  accum_din;
  logic         accum_we;
  logic         clear_kick;
  logic         drain_kick;
  logic         busy;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic [31:0]  dropped_count;

  int pass_cnt;
  int total_cnt;
  logic [63:0] got [DEPTH];
  logic [63:0] exp_tbl [DEPTH];

  accum_array #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .accum_addr    (accum_addr),
    .accum_din     (accum_din),
    .accum_we      (accum_we),
    .clear_kick    (clear_kick),
    .drain_kick    (drain_kick),
    .busy          (busy),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .dropped_count (dropped_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic upd(input logic [31:0] a, input logic [63:0] d);
    accum_we   = 1'b1;
    accum_addr = a;
    accum_din  = d;
    @(negedge clk);
    accum_we   = 1'b0;
  endtask

  task automatic do_clear();
    int cyc;
    clear_kick = 1'b1;
    @(negedge clk);
    clear_kick = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL clear_busy_rise: busy=%b want 1", busy);
    else pass_cnt++;
    cyc = 1;
    while (busy === 1'b1 && cyc < DEPTH + 20) begin
      @(negedge clk);
      cyc++;
    end
    total_cnt++;
    if (busy !== 1'b0 || cyc > DEPTH + 4)
      $display("FAIL clear_latency: busy=%b after %0d cycles want 0 within %0d", busy, cyc, DEPTH + 4);
    else pass_cnt++;
  endtask

  // Kicks a drain, collects every beat into got[], checks stream rules.
  task automatic run_drain(input bit rand_ready, input int n_inject);
    int beats;
    int inj;
    logic stalled;
    logic [511:0] held;
    inj = n_inject;
    drain_kick = 1'b1;
    @(negedge clk);
    drain_kick = 1'b0;
    beats = 0;
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 400 && beats < NB; cyc++) begin
      if (inj > 0) begin
        accum_we   = 1'b1;
        accum_addr = 32'd2;
        accum_din  = 64'd7;
        inj--;
      end else begin
        accum_we = 1'b0;
      end
      if (stalled) begin
        total_cnt++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held)
          $display("FAIL stall_stable: tvalid=%b tdata=%h want 1 %h", m_axis_tvalid, m_axis_tdata, held);
        else pass_cnt++;
      end
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        for (int k = 0; k < 8; k++) got[beats*8 + k] = m_axis_tdata[64*k +: 64];
        total_cnt++;
        if (m_axis_tlast !== (beats == NB - 1))
          $display("FAIL tlast_beat%0d: tlast=%b want %b", beats, m_axis_tlast, beats == NB - 1);
        else pass_cnt++;
        beats++;
        stalled = 1'b0;
      end else if (m_axis_tvalid) begin
        stalled = 1'b1;
        held = m_axis_tdata;
      end
      @(negedge clk);
    end
    accum_we = 1'b0;
    m_axis_tready = 1'b0;
    total_cnt++;
    if (beats !== NB) $display("FAIL drain_beats: got %0d beats want %0d", beats, NB);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL drain_busy_fall: busy=%b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic check_table(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < DEPTH; i++) if (bad < 0 && got[i] !== exp_tbl[i]) bad = i;
    total_cnt++;
    if (bad >= 0)
      $display("FAIL %s: entry %0d = %h want %h", name, bad, got[bad], exp_tbl[bad]);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total_cnt++;
    if ({busy, m_axis_tvalid, m_axis_tlast} !== 3'b000 || m_axis_tdata !== '0 || dropped_count !== 32'd0)
      $display("FAIL reset_state: busy=%b tvalid=%b tlast=%b tdata=%h dropped=%0d want all 0",
               busy, m_axis_tvalid, m_axis_tlast, m_axis_tdata, dropped_count);
    else pass_cnt++;
  endtask

  task automatic test_clear_drain();
    do_clear();
    for (int i = 0; i < DEPTH; i++) exp_tbl[i] = 64'd0;
    run_drain(1'b0, 0);
    check_table("clear_drain_zero");
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int i = 1; i <= 5; i++) upd(32'd3, 64'(i));
    run_drain(1'b0, 0);
    for (int i = 0; i < DEPTH; i++) exp_tbl[i] = 64'd0;
    exp_tbl[3] = 64'd15;
    check_table("back_to_back_addr3");
  endtask

  task automatic test_alternating();
    do_clear();
    for (int i = 0; i < 20; i++) upd(32'(i % 2), 64'd1);
    upd(32'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_drain(1'b0, 0);
    for (int i = 0; i < DEPTH; i++) exp_tbl[i] = 64'd0;
    exp_tbl[0] = 64'd9;
    exp_tbl[1] = 64'd10;
    check_table("alternating_wrap");
  endtask

  task automatic test_dropped();
    do_clear();
    upd(32'd16, 64'd5);
    upd(32'hFFFF_FFFF, 64'd6);
    @(negedge clk);
    total_cnt++;
    if (dropped_count !== 32'd2) $display("FAIL dropped_range: dropped=%0d want 2", dropped_count);
    else pass_cnt++;
    run_drain(1'b0, 3);
    total_cnt++;
    if (dropped_count !== 32'd5) $display("FAIL dropped_busy: dropped=%0d want 5", dropped_count);
    else pass_cnt++;
    run_drain(1'b0, 0);
    for (int i = 0; i < DEPTH; i++) exp_tbl[i] = 64'd0;
    check_table("dropped_table_unchanged");
    do_clear();
    total_cnt++;
    if (dropped_count !== 32'd0) $display("FAIL dropped_clear: dropped=%0d want 0", dropped_count);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int wait_cyc;
    do_clear();
    for (int i = 0; i < DEPTH; i++) upd(32'(i), 64'(100 + i));
    for (int i = 0; i < DEPTH; i++) exp_tbl[i] = 64'(100 + i);
    run_drain(1'b1, 0);
    check_table("backpressure_order");
    drain_kick = 1'b1;
    @(negedge clk);
    drain_kick = 1'b0;
    wait_cyc = 0;
    while (m_axis_tvalid !== 1'b1 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    total_cnt++;
    if (m_axis_tvalid !== 1'b1) $display("FAIL abort_tvalid_seen: tvalid=%b want 1", m_axis_tvalid);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0)
      $display("FAIL abort_reset: tvalid=%b busy=%b tlast=%b tdata=%h want 0 0 0 0",
               m_axis_tvalid, busy, m_axis_tlast, m_axis_tdata);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    test_back_to_back();
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    accum_addr = '0;
    accum_din = '0;
    accum_we = 1'b0;
    clear_kick = 1'b0;
    drain_kick = 1'b0;
    m_axis_tready = 1'b0;
    test_reset();
    test_clear_drain();
    test_back_to_back();
    test_alternating();
    test_dropped();
    test_backpressure();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
